// File: rtl/tc_pkg.sv
// Shared tile geometry for the tensor-core array, the tile accumulator and write-back.
// Holds element widths, tile shape and the row/col to flat-element mapping.
package tc_pkg;

  localparam int TC_DW_OUT = 32;
  localparam int TC_TILE_M = 4;
  localparam int TC_TILE_N = 4;
  localparam int TC_N_ELEM = TC_TILE_M * TC_TILE_N;
  localparam int TC_CNT_W  = 16;

  // Element e = row*TILE_N + col sits at [e*DW_OUT +: DW_OUT] of a packed tile.
  function automatic int tc_elem_idx(input int row, input int col);
    return row * TC_TILE_N + col;
  endfunction

endpackage

// File: rtl/tc_acc_lane.sv
// One accumulator element: first-select adder plus its running-sum register.
// The sum is combinational so the top can capture it directly into the output bank.
module tc_acc_lane
  import tc_pkg::*;
#(
  parameter int DW = TC_DW_OUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_first,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_sum
);

  logic [DW-1:0] r_acc;
  logic [DW-1:0] w_base;

  // On the first chunk of a tile the stale accumulator is ignored.
  assign w_base = i_first ? '0 : r_acc;
  assign o_sum  = w_base + i_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/tc_acc.sv
// Tile accumulator: sums a stream of partial-sum tiles elementwise and hands each
// finished tile to write-back through a one-tile output register.
module tc_acc
  import tc_pkg::*;
#(
  parameter int TILE_M = TC_TILE_M,
  parameter int TILE_N = TC_TILE_N,
  parameter int DW_OUT = TC_DW_OUT,
  parameter int CNT_W  = TC_CNT_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [TILE_M*TILE_N*DW_OUT-1:0]   in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [TILE_M*TILE_N*DW_OUT-1:0]   out_data,
  output logic [CNT_W-1:0]                  out_count
);

  localparam int N_ELEM = TILE_M * TILE_N;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshake: a beat moves on in_valid && in_ready, a tile leaves on
  // out_valid && out_ready; input is open whenever the out bank is empty or draining.
  logic                     r_first;
  logic [CNT_W-1:0]         r_k_cnt;
  logic                     r_out_valid;
  logic [N_ELEM*DW_OUT-1:0] r_out_data;
  logic [CNT_W-1:0]         r_out_count;

  logic                     w_accept;
  logic                     w_load;
  logic [CNT_W-1:0]         w_cnt_next;
  logic [N_ELEM*DW_OUT-1:0] w_sum;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_load    = w_accept && !in_last;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

  // Chunk count including the beat being accepted, saturating.
  assign w_cnt_next = r_first ? CNT_W'(1)
                    : (r_k_cnt == CNT_MAX) ? CNT_MAX
                    : r_k_cnt + CNT_W'(1);

  for (genvar e = 0; e < N_ELEM; e++) begin : g_lane
    tc_acc_lane #(
      .DW(DW_OUT)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_first(r_first),
      .i_data (in_data[e*DW_OUT +: DW_OUT]),
      .o_sum  (w_sum[e*DW_OUT +: DW_OUT])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_first     <= 1'b1;
      r_k_cnt     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      if (w_accept) begin
        if (in_last) begin
          r_out_data  <= w_sum;
          r_out_count <= w_cnt_next;
          r_first     <= 1'b1;
        end else begin
          r_k_cnt <= w_cnt_next;
          r_first <= 1'b0;
        end
      end
      // A new last beat refills the bank in the same cycle the old tile drains.
      if (w_accept && in_last) begin
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
